// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM states, address/length limits
// and the header-byte packing used on the wire.
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         MAX_LEN      = 63;

    function automatic logic [7:0] pack_header(input logic [5:0] len, input logic [1:0] addr);
        return {len, addr};
    endfunction

    // A descriptor is sendable only with a real destination and a non-empty payload.
    function automatic logic desc_ok(input logic [1:0] addr, input logic [5:0] len);
        return (addr != ADDR_INVALID) && (len != 6'd0) && (int'(len) <= MAX_LEN);
    endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// Show-ahead synchronous byte FIFO buffering packet payload; reset flushes it.
// Pushes are ignored when full and pops are ignored when empty.
module router_tx_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [7:0]             i_wdata,
    input  logic                   i_pop,
    output logic [7:0]             o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Transmit end of the router pkt_valid/data_in/busy protocol: header, payload, parity, then a gap.
// Define PKT_TX_ERR_INJECT_EN to add err_inject, which corrupts bit 0 of the packet's parity byte.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       busy,
`ifdef PKT_TX_ERR_INJECT_EN
    input  logic       err_inject,
`endif
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_active,
    output logic       pkt_done,
    output logic       req_drop
);

    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    tx_state_t     r_state, w_state_next;
    logic [1:0]    r_addr, w_addr_next;
    logic [5:0]    r_len, w_len_next;
    logic [5:0]    r_remain, w_remain_next;
    logic [7:0]    r_parity, w_parity_next;
    logic [3:0]    r_gap, w_gap_next;
    logic          r_pkt_valid, w_pkt_valid_next;
    logic [7:0]    r_data_out, w_data_next;
    logic          r_tx_active, w_tx_active_next;
    logic          r_pkt_done, w_pkt_done_next;
    logic          r_req_drop, w_req_drop_next;
    logic          w_pop_req;
    logic          w_fifo_pop;
    logic          w_accept;
    logic [7:0]    w_flip;
    logic [7:0]    w_fifo_rdata;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;

`ifdef PKT_TX_ERR_INJECT_EN
    logic r_inject, w_inject_next;
    assign w_flip = {7'd0, r_inject};
`else
    assign w_flip = 8'd0;
`endif

    assign req_ready  = (r_state == ST_IDLE);
    assign pl_ready   = !w_fifo_full;
    assign pkt_valid  = r_pkt_valid;
    assign data_out   = r_data_out;
    assign tx_active  = r_tx_active;
    assign pkt_done   = r_pkt_done;
    assign req_drop   = r_req_drop;
    assign w_accept   = r_tx_active && !busy;
    assign w_fifo_pop = w_pop_req && !w_fifo_empty;

    router_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (pl_valid),
        .i_wdata (pl_data),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= 2'd0;
            r_len       <= 6'd0;
            r_remain    <= 6'd0;
            r_parity    <= 8'd0;
            r_gap       <= 4'd0;
            r_pkt_valid <= 1'b0;
            r_data_out  <= 8'd0;
            r_tx_active <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_req_drop  <= 1'b0;
`ifdef PKT_TX_ERR_INJECT_EN
            r_inject    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_len       <= w_len_next;
            r_remain    <= w_remain_next;
            r_parity    <= w_parity_next;
            r_gap       <= w_gap_next;
            r_pkt_valid <= w_pkt_valid_next;
            r_data_out  <= w_data_next;
            r_tx_active <= w_tx_active_next;
            r_pkt_done  <= w_pkt_done_next;
            r_req_drop  <= w_req_drop_next;
`ifdef PKT_TX_ERR_INJECT_EN
            r_inject    <= w_inject_next;
`endif
        end
    end

    // The payload is only started once it is fully buffered, so PAYLOAD never sees an empty FIFO.
    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_len_next       = r_len;
        w_remain_next    = r_remain;
        w_parity_next    = r_parity;
        w_gap_next       = r_gap;
        w_pkt_valid_next = r_pkt_valid;
        w_data_next      = r_data_out;
        w_tx_active_next = r_tx_active;
        w_pkt_done_next  = 1'b0;
        w_req_drop_next  = 1'b0;
        w_pop_req        = 1'b0;
`ifdef PKT_TX_ERR_INJECT_EN
        w_inject_next    = r_inject;
`endif
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_addr_next = req_addr;
                    w_len_next  = req_len;
`ifdef PKT_TX_ERR_INJECT_EN
                    w_inject_next = err_inject;
`endif
                    if (desc_ok(req_addr, req_len)) begin
                        w_state_next = ST_WAIT;
                    end else begin
                        w_req_drop_next = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (w_fifo_count >= CW'(r_len)) begin
                    w_state_next     = ST_HEADER;
                    w_data_next      = pack_header(r_len, r_addr);
                    w_pkt_valid_next = 1'b1;
                    w_tx_active_next = 1'b1;
                    w_parity_next    = 8'd0;
                    w_remain_next    = r_len;
                end
            end
            ST_HEADER: begin
                if (w_accept) begin
                    w_parity_next = r_data_out;
                    w_data_next   = w_fifo_rdata;
                    w_pop_req     = 1'b1;
                    w_state_next  = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    w_parity_next = r_parity ^ r_data_out;
                    if (r_remain == 6'd1) begin
                        w_data_next      = r_parity ^ r_data_out ^ w_flip;
                        w_pkt_valid_next = 1'b0;
                        w_state_next     = ST_PARITY;
                    end else begin
                        w_data_next   = w_fifo_rdata;
                        w_pop_req     = 1'b1;
                        w_remain_next = r_remain - 6'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_accept) begin
                    w_pkt_done_next  = 1'b1;
                    w_tx_active_next = 1'b0;
                    w_data_next      = 8'd0;
                    w_gap_next       = 4'd0;
                    w_state_next     = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_gap_next = r_gap + 4'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: a cycle-by-cycle vector table for the basic, busy-stall and
// drop cases, then hand-written sequences for slow payload, reset mid-packet and back-to-back gaps.
module tb_router_pkt_tx;

   localparam int GAP_CYCLES = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       reqValid;
   logic       reqReady;
   logic [1:0] reqAddr;
   logic [5:0] reqLen;
   logic       plValid;
   logic       plReady;
   logic [7:0] plData;
   logic       busyIn;
   logic       errInject;
   logic       pktValid;
   logic [7:0] dataOut;
   logic       txActive;
   logic       pktDone;
   logic       reqDrop;

   int checks   = 0;
   int failures = 0;

   logic [7:0] expBytes[$];

   typedef struct {
      logic       reqValid;
      logic [1:0] reqAddr;
      logic [5:0] reqLen;
      logic       plValid;
      logic [7:0] plData;
      logic       busyIn;
      logic       expPktValid;
      logic [7:0] expData;
      logic       expTxActive;
      logic       expPktDone;
      logic       expReqDrop;
      logic       expReqReady;
   } vec_t;

   vec_t vecs[$];

   always #5 clock = ~clock;

   router_pkt_tx #(.FIFO_DEPTH(64), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (reqValid),
      .req_ready (reqReady),
      .req_addr  (reqAddr),
      .req_len   (reqLen),
      .pl_valid  (plValid),
      .pl_ready  (plReady),
      .pl_data   (plData),
      .busy      (busyIn),
`ifdef PKT_TX_ERR_INJECT_EN
      .err_inject(errInject),
`endif
      .pkt_valid (pktValid),
      .data_out  (dataOut),
      .tx_active (txActive),
      .pkt_done  (pktDone),
      .req_drop  (reqDrop)
   );

   // Safety net so a stuck DUT can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [7:0] b2(input logic b);
      return {7'd0, b};
   endfunction

   function automatic vec_t mk(input logic rv, input logic [1:0] ra, input logic [5:0] rl,
                               input logic pv, input logic [7:0] pd, input logic bz,
                               input logic eV, input logic [7:0] eD, input logic eT,
                               input logic eDn, input logic eDr, input logic eR);
      vec_t v;
      v.reqValid = rv; v.reqAddr = ra; v.reqLen = rl;
      v.plValid = pv; v.plData = pd; v.busyIn = bz;
      v.expPktValid = eV; v.expData = eD; v.expTxActive = eT;
      v.expPktDone = eDn; v.expReqDrop = eDr; v.expReqReady = eR;
      return v;
   endfunction

   // Advance one clock; the window just after the edge is where inputs change and outputs are sampled.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s got=%h exp=%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reqValid = v.reqValid;
      reqAddr  = v.reqAddr;
      reqLen   = v.reqLen;
      plValid  = v.plValid;
      plData   = v.plData;
      busyIn   = v.busyIn;
   endtask

   task automatic pushByte(input logic [7:0] d);
      plValid = 1'b1;
      plData  = d;
      tick();
      plValid = 1'b0;
   endtask

   task automatic sendDescriptor(input logic [1:0] a, input logic [5:0] l);
      int waitCnt = 0;
      while (reqReady !== 1'b1 && waitCnt < 50) begin
         tick();
         waitCnt++;
      end
      checkOutput("descReadyWait", b2(reqReady), 8'd1);
      reqValid = 1'b1;
      reqAddr  = a;
      reqLen   = l;
      tick();
      reqValid = 1'b0;
   endtask

   // Expects header, expBytes, parity on consecutive cycles, then the pkt_done cycle.
   task automatic expectPacket(input logic [7:0] header, input logic [7:0] parity);
      int waitCnt = 0;
      while (pktValid !== 1'b1 && waitCnt < 100) begin
         tick();
         waitCnt++;
      end
      checkOutput("hdrValid", b2(pktValid), 8'd1);
      checkOutput("hdrData", dataOut, header);
      foreach (expBytes[k]) begin
         tick();
         checkOutput($sformatf("pl%0d.valid", k), b2(pktValid), 8'd1);
         checkOutput($sformatf("pl%0d.data", k), dataOut, expBytes[k]);
      end
      tick();
      checkOutput("parValid", b2(pktValid), 8'd0);
      checkOutput("parData", dataOut, parity);
      checkOutput("parTxActive", b2(txActive), 8'd1);
      tick();
      checkOutput("donePulse", b2(pktDone), 8'd1);
      checkOutput("doneTxActive", b2(txActive), 8'd0);
      checkOutput("doneData", dataOut, 8'd0);
   endtask

   initial begin
      int gapCnt;
      int waitCnt;

      reset     = 1'b1;
      reqValid  = 1'b0;
      reqAddr   = 2'd0;
      reqLen    = 6'd0;
      plValid   = 1'b0;
      plData    = 8'd0;
      busyIn    = 1'b0;
      errInject = 1'b0;

      #1;
      checkOutput("rst.reqReady", b2(reqReady), 8'd1);
      checkOutput("rst.plReady", b2(plReady), 8'd1);
      checkOutput("rst.pktValid", b2(pktValid), 8'd0);
      checkOutput("rst.dataOut", dataOut, 8'd0);
      checkOutput("rst.txActive", b2(txActive), 8'd0);
      checkOutput("rst.pktDone", b2(pktDone), 8'd0);
      checkOutput("rst.reqDrop", b2(reqDrop), 8'd0);
      tick();
      tick();
      reset = 1'b0;

      // Test 1: addr 1, len 3, payload 11 22 33; header 0D, parity 0D.
      vecs.push_back(mk(1, 2'd1, 6'd3, 1, 8'h11, 0,  0, 8'h00, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'd0, 6'd0, 1, 8'h22, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 1, 8'h33, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  1, 8'h0D, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  1, 8'h11, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  1, 8'h22, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  1, 8'h33, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h0D, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 1, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1));
      // Test 2: same packet, busy for two cycles while 22 is on the wire.
      vecs.push_back(mk(1, 2'd1, 6'd3, 1, 8'h11, 0,  0, 8'h00, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'd0, 6'd0, 1, 8'h22, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 1, 8'h33, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  1, 8'h0D, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  1, 8'h11, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 1,  1, 8'h22, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 1,  1, 8'h22, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  1, 8'h22, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  1, 8'h33, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h0D, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 1, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1));
      // Test 3: addr 3 then len 0 are both dropped without leaving IDLE.
      vecs.push_back(mk(1, 2'd3, 6'd5, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1));
      vecs.push_back(mk(1, 2'd2, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 1, 1));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 1, 1));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'd0, 6'd0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         checkOutput($sformatf("row%0d.pktValid", i), b2(pktValid), b2(vecs[i].expPktValid));
         checkOutput($sformatf("row%0d.dataOut", i), dataOut, vecs[i].expData);
         checkOutput($sformatf("row%0d.txActive", i), b2(txActive), b2(vecs[i].expTxActive));
         checkOutput($sformatf("row%0d.pktDone", i), b2(pktDone), b2(vecs[i].expPktDone));
         checkOutput($sformatf("row%0d.reqDrop", i), b2(reqDrop), b2(vecs[i].expReqDrop));
         checkOutput($sformatf("row%0d.reqReady", i), b2(reqReady), b2(vecs[i].expReqReady));
         applyStimulus(vecs[i]);
         tick();
      end

      // Test 4: len 2 with payload bytes four cycles apart; header waits for both bytes.
      sendDescriptor(2'd2, 6'd2);
      pushByte(8'hA5);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("slow%0d.noHdr", i), b2(pktValid), 8'd0);
      end
      pushByte(8'h5A);
      checkOutput("slow.noHdrYet", b2(txActive), 8'd0);
      expBytes = '{8'hA5, 8'h5A};
      expectPacket(8'h0A, 8'hF5);

      // Test 5: reset while in PAYLOAD aborts at once and flushes the buffered bytes.
      sendDescriptor(2'd0, 6'd4);
      pushByte(8'h01);
      pushByte(8'h02);
      pushByte(8'h03);
      pushByte(8'h04);
      waitCnt = 0;
      while (!(pktValid === 1'b1 && dataOut === 8'h02) && waitCnt < 30) begin
         tick();
         waitCnt++;
      end
      checkOutput("rstMid.reachPayload", dataOut, 8'h02);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rstMid.pktValid", b2(pktValid), 8'd0);
      checkOutput("rstMid.dataOut", dataOut, 8'd0);
      checkOutput("rstMid.txActive", b2(txActive), 8'd0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      checkOutput("rstMid.reqReady", b2(reqReady), 8'd1);
      checkOutput("rstMid.plReady", b2(plReady), 8'd1);
      sendDescriptor(2'd0, 6'd1);
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput($sformatf("flush%0d.noHdr", i), b2(pktValid), 8'd0);
      end
      pushByte(8'h77);
      expBytes = '{8'h77};
      expectPacket(8'h04, 8'h73);

      // Back-to-back: addr 0 then addr 2, both payloads pre-filled; IDLE returns after the gap.
      pushByte(8'h5C);
      pushByte(8'hC3);
      sendDescriptor(2'd0, 6'd1);
      expBytes = '{8'h5C};
      expectPacket(8'h04, 8'h58);
      gapCnt = 0;
      while (reqReady !== 1'b1 && gapCnt < 20) begin
         gapCnt++;
         tick();
      end
      checkOutput("b2b.gapCycles", 8'(gapCnt), 8'(GAP_CYCLES));
      sendDescriptor(2'd2, 6'd1);
      expBytes = '{8'hC3};
      expectPacket(8'h06, 8'hC5);

`ifdef PKT_TX_ERR_INJECT_EN
      // Test 6: corrupted parity only; header and payload unchanged.
      errInject = 1'b1;
      sendDescriptor(2'd1, 6'd3);
      errInject = 1'b0;
      pushByte(8'h11);
      pushByte(8'h22);
      pushByte(8'h33);
      expBytes = '{8'h11, 8'h22, 8'h33};
      expectPacket(8'h0D, 8'h0C);
`endif

      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
